// File: rtl/a_ext_pkg.sv
// -----------------------------------------------------------------------------
// a_ext_pkg
// Shared types for the RV32A atomic-memory-operation engine: the AMO opcode
// encoding, the packed structs that travel between the LSU and the AMO unit,
// and the engine's FSM state encoding.
// Ports: none (package).
// -----------------------------------------------------------------------------
package a_ext_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      NONE = 4'd0,
      LR   = 4'd1,
      SC   = 4'd2,
      SWAP = 4'd3,
      ADD  = 4'd4,
      XOR  = 4'd5,
      AND  = 4'd6,
      OR   = 4'd7,
      MIN  = 4'd8,
      MAX  = 4'd9,
      MINU = 4'd10,
      MAXU = 4'd11
   } type_amo_ops_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } type_amo_states_e;

   typedef struct packed {
      logic [XLEN-1:0] lsu_addr;
      logic [XLEN-1:0] rs2_operand;
      logic [XLEN-1:0] r_data;
   } type_lsu2amo_data_s;

   typedef struct packed {
      logic          is_amo;
      type_amo_ops_e amo_ops;
      logic          ack;
   } type_lsu2amo_ctrl_s;

   typedef struct packed {
      logic [XLEN-1:0] lsu_addr;
      logic [XLEN-1:0] w_data;
      logic [XLEN-1:0] rd_result;
   } type_amo2lsu_data_s;

   typedef struct packed {
      logic rd_req;
      logic wr_req;
      logic done;
   } type_amo2lsu_ctrl_s;

endpackage

// File: rtl/amo_alu.sv
// -----------------------------------------------------------------------------
// amo_alu
// Purely combinational modify stage of the AMO read-modify-write: combines the
// old memory value with the rs2 operand according to the AMO opcode.
// Ports:
//   op_i          AMO opcode (type_amo_ops_e encoding)
//   buf_data_i    old memory value captured during the read phase
//   rs2_i         rs2 operand latched at request time
//   w_data_o      value to be written back to memory
// -----------------------------------------------------------------------------
module amo_alu
   import a_ext_pkg::*;
(
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] buf_data_i,
   input  logic [XLEN-1:0] rs2_i,
   output logic [XLEN-1:0] w_data_o
);

   type_amo_ops_e op;

   assign op = type_amo_ops_e'(op_i);

   // Min/max keep the old value on a tie so an equal compare never rewrites
   // memory with a different bit pattern source. Opcodes that carry no modify
   // step (LR, NONE, unused encodings) write the old value back unchanged.
   always_comb begin
      w_data_o = buf_data_i;
      case (op)
         SWAP, SC: w_data_o = rs2_i;
         ADD:      w_data_o = buf_data_i + rs2_i;
         XOR:      w_data_o = buf_data_i ^ rs2_i;
         AND:      w_data_o = buf_data_i & rs2_i;
         OR:       w_data_o = buf_data_i | rs2_i;
         MIN:      w_data_o = ($signed(rs2_i) < $signed(buf_data_i)) ? rs2_i : buf_data_i;
         MAX:      w_data_o = ($signed(rs2_i) > $signed(buf_data_i)) ? rs2_i : buf_data_i;
         MINU:     w_data_o = (rs2_i < buf_data_i) ? rs2_i : buf_data_i;
         MAXU:     w_data_o = (rs2_i > buf_data_i) ? rs2_i : buf_data_i;
         default:  w_data_o = buf_data_i;
      endcase
   end

endmodule

// File: rtl/amo_unit.sv
// -----------------------------------------------------------------------------
// amo_unit
// RV32A atomic-memory-operation engine sitting between the LSU and the data
// memory port. It sequences the read-modify-write of an AMO through LSU-issued
// memory requests, tracks the LR/SC reservation and hands the rd result (old
// memory value, or SC status) back to the LSU with a one-cycle done pulse.
//
// Ports:
//   clk             system clock
//   rst_n           synchronous reset, active HIGH despite the name
//   lsu2amo_data_i  {lsu_addr, rs2_operand, r_data}        (type_lsu2amo_data_s)
//   lsu2amo_ctrl_i  {is_amo, amo_ops[3:0], ack}            (type_lsu2amo_ctrl_s)
//   amo2lsu_data_o  {lsu_addr, w_data, rd_result}          (type_amo2lsu_data_s)
//   amo2lsu_ctrl_o  {rd_req, wr_req, done}                 (type_amo2lsu_ctrl_s)
//
// Build option:
//   AMO_SC_ADDR_CHECK_EN  when defined, an SC only succeeds if its address
//                         matches the reserved address; otherwise a valid
//                         reservation alone is enough.
// -----------------------------------------------------------------------------
module amo_unit
   import a_ext_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3*XLEN-1:0] lsu2amo_data_i,
   input  logic [5:0]        lsu2amo_ctrl_i,
   output logic [3*XLEN-1:0] amo2lsu_data_o,
   output logic [2:0]        amo2lsu_ctrl_o
);

   type_lsu2amo_data_s lsu_data;
   type_lsu2amo_ctrl_s lsu_ctrl;
   type_amo2lsu_data_s out_data;
   type_amo2lsu_ctrl_s out_ctrl;

   type_amo_states_e state_q, state_d;
   type_amo_ops_e    op_q, op_d;
   logic [XLEN-1:0]  addr_q, addr_d;
   logic [XLEN-1:0]  rs2_q, rs2_d;
   logic [XLEN-1:0]  amo_buffer_data_q, amo_buffer_data_d;
   logic             res_valid_q, res_valid_d;
   logic [XLEN-1:0]  res_addr_q, res_addr_d;

   logic             sc_hit;
   logic [XLEN-1:0]  alu_w_data;

   assign lsu_data       = type_lsu2amo_data_s'(lsu2amo_data_i);
   assign lsu_ctrl       = type_lsu2amo_ctrl_s'(lsu2amo_ctrl_i);
   assign amo2lsu_data_o = out_data;
   assign amo2lsu_ctrl_o = out_ctrl;

   amo_alu u_amo_alu (
      .op_i       (op_q),
      .buf_data_i (amo_buffer_data_q),
      .rs2_i      (rs2_q),
      .w_data_o   (alu_w_data)
   );

   // SC success is decided from the incoming request, since that address is
   // exactly what gets latched on the same edge.
   always_comb begin
`ifdef AMO_SC_ADDR_CHECK_EN
      sc_hit = res_valid_q && (lsu_data.lsu_addr == res_addr_q);
`else
      sc_hit = res_valid_q;
`endif
   end

   // Next-state and output logic. The SC status is parked in the buffer
   // register (0 = success, 1 = failure) so that DONE always returns the
   // buffer as rd_result, whatever the opcode was.
   always_comb begin
      state_d           = state_q;
      op_d              = op_q;
      addr_d            = addr_q;
      rs2_d             = rs2_q;
      amo_buffer_data_d = amo_buffer_data_q;
      res_valid_d       = res_valid_q;
      res_addr_d        = res_addr_q;
      out_data          = '0;
      out_ctrl          = '0;

      case (state_q)
         IDLE: begin
            if (lsu_ctrl.is_amo && (lsu_ctrl.amo_ops != NONE)) begin
               op_d   = lsu_ctrl.amo_ops;
               addr_d = lsu_data.lsu_addr;
               rs2_d  = lsu_data.rs2_operand;
               if (lsu_ctrl.amo_ops == SC) begin
                  res_valid_d = 1'b0;
                  if (sc_hit) begin
                     amo_buffer_data_d = '0;
                     state_d           = WRITE;
                  end else begin
                     amo_buffer_data_d = {{(XLEN-1){1'b0}}, 1'b1};
                     state_d           = DONE;
                  end
               end else begin
                  state_d = READ;
               end
            end
         end

         READ: begin
            out_ctrl.rd_req   = 1'b1;
            out_data.lsu_addr = addr_q;
            if (lsu_ctrl.ack) begin
               amo_buffer_data_d = lsu_data.r_data;
               if (op_q == LR) begin
                  res_valid_d = 1'b1;
                  res_addr_d  = addr_q;
                  state_d     = DONE;
               end else begin
                  state_d = WRITE;
               end
            end
         end

         WRITE: begin
            out_ctrl.wr_req   = 1'b1;
            out_data.lsu_addr = addr_q;
            out_data.w_data   = alu_w_data;
            if (lsu_ctrl.ack) begin
               // A completed RMW store to the reserved word kills the
               // reservation; SC already dropped it when it was accepted.
               if ((op_q != SC) && res_valid_q && (res_addr_q == addr_q)) begin
                  res_valid_d = 1'b0;
               end
               state_d = DONE;
            end
         end

         DONE: begin
            out_ctrl.done      = 1'b1;
            out_data.rd_result = amo_buffer_data_q;
            state_d            = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset is synchronous and active high.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state_q           <= IDLE;
         op_q              <= NONE;
         addr_q            <= '0;
         rs2_q             <= '0;
         amo_buffer_data_q <= '0;
         res_valid_q       <= 1'b0;
         res_addr_q        <= '0;
      end else begin
         state_q           <= state_d;
         op_q              <= op_d;
         addr_q            <= addr_d;
         rs2_q             <= rs2_d;
         amo_buffer_data_q <= amo_buffer_data_d;
         res_valid_q       <= res_valid_d;
         res_addr_q        <= res_addr_d;
      end
   end

endmodule

// File: tb/tb_amo_unit.sv
// -----------------------------------------------------------------------------
// tb_amo_unit
// Self-checking bench for amo_unit. The bench plays the memory (an associative
// array) and keeps its own model of the LR/SC reservation; expected results
// come from the RV32A rules written as plain arithmetic.
// -----------------------------------------------------------------------------
module tb_amo_unit;
   import a_ext_pkg::*;

   logic               clk;
   logic               rst_n;
   type_lsu2amo_data_s data_i;
   type_lsu2amo_ctrl_s ctrl_i;
   type_amo2lsu_data_s data_o;
   type_amo2lsu_ctrl_s ctrl_o;
   logic [95:0]        data_o_raw;
   logic [2:0]         ctrl_o_raw;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [logic [31:0]];
   bit          res_v = 1'b0;
   logic [31:0] res_a = '0;
   logic [31:0] last_rd;
   logic [31:0] last_w;

   amo_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .lsu2amo_data_i (data_i),
      .lsu2amo_ctrl_i (ctrl_i),
      .amo2lsu_data_o (data_o_raw),
      .amo2lsu_ctrl_o (ctrl_o_raw)
   );

   assign data_o = type_amo2lsu_data_s'(data_o_raw);
   assign ctrl_o = type_amo2lsu_ctrl_s'(ctrl_o_raw);

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference result of the modify step, straight from the ISA definition.
   function automatic logic [31:0] model_new(input logic [3:0] op, input logic [31:0] old_v,
                                             input logic [31:0] rs2);
      int a;
      int b;
      a = old_v;
      b = rs2;
      case (op)
         4'd3:  return rs2;
         4'd4:  return old_v + rs2;
         4'd5:  return old_v ^ rs2;
         4'd6:  return old_v & rs2;
         4'd7:  return old_v | rs2;
         4'd8:  return (a <= b) ? old_v : rs2;
         4'd9:  return (a >= b) ? old_v : rs2;
         4'd10: return (old_v <= rs2) ? old_v : rs2;
         4'd11: return (old_v >= rs2) ? old_v : rs2;
         default: return old_v;
      endcase
   endfunction

   // Issue one AMO, act as memory with the given ack stalls, and check the
   // handshake, write data, rd result and latency against the model.
   task automatic run_amo(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rs2,
                          input int rd_stall, input int wr_stall);
      logic [31:0] old_v;
      logic [31:0] exp_w;
      logic [31:0] exp_rd;
      bit          do_rd;
      bit          do_wr;
      bit          hit;
      int          exp_lat;
      int          rds;
      int          wrs;
      int          lat;
      int          rs;
      int          ws;
      bit          seen_done;

      if (!mem.exists(addr)) mem[addr] = $urandom;
      old_v = mem[addr];
      exp_w = 32'h0;
      if (op == 4'd1) begin
         do_rd = 1; do_wr = 0; exp_rd = old_v; exp_lat = 2;
         res_v = 1; res_a = addr;
      end else if (op == 4'd2) begin
`ifdef AMO_SC_ADDR_CHECK_EN
         hit = res_v && (res_a == addr);
`else
         hit = res_v;
`endif
         do_rd = 0; do_wr = hit; exp_w = rs2;
         exp_rd = hit ? 32'd0 : 32'd1;
         exp_lat = hit ? 2 : 1;
         res_v = 0;
      end else begin
         do_rd = 1; do_wr = 1; exp_w = model_new(op, old_v, rs2);
         exp_rd = old_v; exp_lat = 3;
         if (res_v && res_a == addr) res_v = 0;
      end
      if (do_rd) exp_lat += rd_stall;
      if (do_wr) exp_lat += wr_stall;

      last_rd = 32'hDEADBEEF;
      last_w  = 32'hDEADBEEF;
      rds = 0; wrs = 0; lat = 0; rs = rd_stall; ws = wr_stall; seen_done = 0;

      @(negedge clk);
      ctrl_i = '{is_amo: 1'b1, amo_ops: type_amo_ops_e'(op), ack: 1'b0};
      data_i = '{lsu_addr: addr, rs2_operand: rs2, r_data: $urandom};
      @(posedge clk);
      for (int c = 0; c < 64 && !seen_done; c++) begin
         @(negedge clk);
         lat++;
         if (ctrl_o.done) begin
            seen_done = 1;
            last_rd   = data_o.rd_result;
            ctrl_i    = '{is_amo: 1'b0, amo_ops: NONE, ack: 1'($urandom)};
         end else begin
            // Junk on the request lines must be ignored mid-operation.
            ctrl_i.is_amo  = 1'($urandom);
            ctrl_i.amo_ops = type_amo_ops_e'($urandom_range(0, 15));
            data_i.lsu_addr    = $urandom;
            data_i.rs2_operand = $urandom;
            ctrl_i.ack = 1'b0;
            if (ctrl_o.rd_req) begin
               rds++;
               checks++;
               if (data_o.lsu_addr !== addr) begin
                  errors++;
                  $display("[TB] FAIL rd_addr op=%0d got=%h exp=%h", op, data_o.lsu_addr, addr);
               end
               if (rs > 0) rs--;
               else begin
                  ctrl_i.ack = 1'b1;
                  data_i.r_data = mem[addr];
               end
            end else if (ctrl_o.wr_req) begin
               wrs++;
               if (ws > 0) ws--;
               else begin
                  ctrl_i.ack = 1'b1;
                  last_w = data_o.w_data;
                  checks++;
                  if (data_o.lsu_addr !== addr || data_o.w_data !== exp_w) begin
                     errors++;
                     $display("[TB] FAIL wr_data op=%0d got=%h@%h exp=%h@%h",
                              op, data_o.w_data, data_o.lsu_addr, exp_w, addr);
                  end
                  mem[addr] = exp_w;
               end
            end else begin
               ctrl_i.ack = 1'($urandom);
            end
         end
      end

      checks++;
      if (!seen_done) begin
         errors++;
         $display("[TB] FAIL done_timeout op=%0d got=no_done exp=done", op);
      end
      checks++;
      if (last_rd !== exp_rd) begin
         errors++;
         $display("[TB] FAIL rd_result op=%0d got=%h exp=%h", op, last_rd, exp_rd);
      end
      checks++;
      if (rds != (do_rd ? rd_stall + 1 : 0) || wrs != (do_wr ? wr_stall + 1 : 0)) begin
         errors++;
         $display("[TB] FAIL req_cycles op=%0d got=rd%0d/wr%0d exp=rd%0d/wr%0d", op, rds, wrs,
                  do_rd ? rd_stall + 1 : 0, do_wr ? wr_stall + 1 : 0);
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("[TB] FAIL latency op=%0d got=%0d exp=%0d", op, lat, exp_lat);
      end

      // Done is a single-cycle pulse followed by an idle, quiet interface.
      @(negedge clk);
      ctrl_i.ack = 1'b0;
      checks++;
      if (ctrl_o !== 3'b000) begin
         errors++;
         $display("[TB] FAIL post_done_ctrl op=%0d got=%b exp=000", op, ctrl_o);
      end
   endtask

   // Reset leaves every output at zero and the reservation invalid.
   task automatic test_reset();
      rst_n  = 1'b1;
      ctrl_i = '0;
      data_i = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (data_o !== 96'h0 || ctrl_o !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_outputs got=%h/%b exp=0/000", data_o, ctrl_o);
      end
      rst_n = 1'b0;
      res_v = 0;
      run_amo(4'd2, 32'h1000, 32'h11111111, 0, 0);
      checks++;
      if (last_rd !== 32'd1) begin
         errors++;
         $display("[TB] FAIL reset_sc got=%h exp=00000001", last_rd);
      end
   endtask

   // LR then SC hit then SC miss on the same word.
   task automatic test_lr_sc();
      mem[32'h1000] = 32'h10;
      run_amo(4'd1, 32'h1000, $urandom, 0, 0);
      checks++;
      if (last_rd !== 32'h10) begin
         errors++;
         $display("[TB] FAIL lr_result got=%h exp=00000010", last_rd);
      end
      run_amo(4'd2, 32'h1000, 32'hA5A5A5A5, 0, 0);
      checks++;
      if (last_rd !== 32'h0 || last_w !== 32'hA5A5A5A5) begin
         errors++;
         $display("[TB] FAIL sc_hit got=rd%h/w%h exp=rd00000000/wA5A5A5A5", last_rd, last_w);
      end
      run_amo(4'd2, 32'h1000, 32'h12345678, 0, 0);
      checks++;
      if (last_rd !== 32'h1) begin
         errors++;
         $display("[TB] FAIL sc_miss got=%h exp=00000001", last_rd);
      end
   endtask

   // Directed read-modify-write cases with hand-computed write data.
   task automatic test_rmw();
      logic [3:0]  ops  [7] = '{4'd4, 4'd6, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
      logic [31:0] rs2s [7] = '{32'h8, 32'h8, 32'h8, 32'h80000008, 32'h80000008,
                                32'h80000008, 32'h80000008};
      logic [31:0] exps [7] = '{32'h18, 32'h0, 32'h8, 32'h80000008, 32'h10,
                                32'h10, 32'h80000008};
      for (int i = 0; i < 7; i++) begin
         mem[32'h2000] = 32'h10;
         run_amo(ops[i], 32'h2000, rs2s[i], 0, 0);
         checks++;
         if (last_w !== exps[i] || last_rd !== 32'h10) begin
            errors++;
            $display("[TB] FAIL rmw_directed op=%0d got=w%h/rd%h exp=w%h/rd00000010",
                     ops[i], last_w, last_rd, exps[i]);
         end
      end
      // Equal operands on signed min/max.
      mem[32'h2000] = 32'hFFFFFFF0;
      run_amo(4'd8, 32'h2000, 32'hFFFFFFF0, 0, 0);
      run_amo(4'd9, 32'h2000, 32'hFFFFFFF0, 0, 0);
   endtask

   // Read held for five cycles without ack, then a stalled write.
   task automatic test_ack_stall();
      mem[32'h3000] = 32'h10;
      run_amo(4'd4, 32'h3000, 32'h8, 5, 0);
      run_amo(4'd1, 32'h3000, 32'h0, 3, 0);
      run_amo(4'd2, 32'h3000, 32'h77, 0, 4);
   endtask

   // A store to the reserved word kills the reservation.
   task automatic test_reservation_kill();
      run_amo(4'd1, 32'h1004, 32'h0, 0, 0);
      run_amo(4'd7, 32'h1004, $urandom, 0, 0);
      run_amo(4'd2, 32'h1004, 32'h5, 0, 0);
      run_amo(4'd1, 32'h1004, 32'h0, 0, 0);
      run_amo(4'd7, 32'h1008, $urandom, 0, 0);
      run_amo(4'd2, 32'h1004, 32'h6, 0, 0);
   endtask

   // Reset while a write is pending aborts the operation and the reservation.
   task automatic test_reset_mid_write();
      bit in_write;
      run_amo(4'd1, 32'h4000, 32'h0, 0, 0);
      @(negedge clk);
      ctrl_i = '{is_amo: 1'b1, amo_ops: ADD, ack: 1'b0};
      data_i = '{lsu_addr: 32'h4000, rs2_operand: 32'h1, r_data: 32'h0};
      @(posedge clk);
      in_write = 0;
      for (int c = 0; c < 16 && !in_write; c++) begin
         @(negedge clk);
         ctrl_i.is_amo = 1'b0;
         ctrl_i.ack    = 1'b0;
         if (ctrl_o.wr_req) in_write = 1;
         else if (ctrl_o.rd_req) begin
            ctrl_i.ack    = 1'b1;
            data_i.r_data = mem[32'h4000];
         end
      end
      checks++;
      if (!in_write) begin
         errors++;
         $display("[TB] FAIL mid_write_reach got=no_wr_req exp=wr_req");
      end
      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      res_v = 0;
      checks++;
      if (data_o !== 96'h0 || ctrl_o !== 3'b000) begin
         errors++;
         $display("[TB] FAIL mid_write_reset got=%h/%b exp=0/000", data_o, ctrl_o);
      end
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (ctrl_o !== 3'b000) begin
            errors++;
            $display("[TB] FAIL post_reset_quiet got=%b exp=000", ctrl_o);
         end
      end
      run_amo(4'd2, 32'h4000, 32'h9, 0, 0);
   endtask

   // Random mix of RMWs and LR/SC pairs over a few addresses.
   task automatic test_random();
      logic [31:0] addrs [3] = '{32'h5000, 32'h5004, 32'h6000};
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 2) == 0) begin
            run_amo(4'd1, addrs[$urandom_range(0, 2)], $urandom, $urandom_range(0, 2), 0);
            if ($urandom_range(0, 1) == 1)
               run_amo(4'd4, addrs[$urandom_range(0, 2)], $urandom, 0, $urandom_range(0, 2));
            run_amo(4'd2, addrs[$urandom_range(0, 2)], $urandom, 0, $urandom_range(0, 2));
         end else begin
            run_amo(4'($urandom_range(1, 11)), addrs[$urandom_range(0, 2)], $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2));
         end
      end
   endtask

   // Run every scenario in order and report.
   initial begin
      test_reset();
      test_lr_sc();
      test_rmw();
      test_ack_stall();
      test_reservation_kill();
      test_reset_mid_write();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
